// File: rtl/lcd_fill_ctrl_pkg.sv
// Shared constants for the LCD rectangle-fill controller: panel command
// bytes, the sequencer and handshake state encodings, and the helper that
// maps a header position to its command/data byte.
package lcd_fill_ctrl_pkg;

    // Panel commands used to open a drawing window and stream pixels
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    // Fill sequencer states
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_READY = 3'd1;
    localparam logic [2:0] ST_ISSUE      = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK   = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE  = 3'd4;
    localparam logic [2:0] ST_FINISH     = 3'd5;

    // Byte handshake phases
    localparam logic [1:0] HS_IDLE = 2'd0;
    localparam logic [1:0] HS_LOAD = 2'd1;
    localparam logic [1:0] HS_WAIT = 2'd2;

    // Header is 11 bytes: CASET + 4, PASET + 4, RAMWR
    localparam logic [3:0] HDR_LAST = 4'd10;

    // Header byte at position idx, returned as {is_cmd, byte}.
    // Coordinates are 9 bits, sent zero-extended to 16 bits, MSB first.
    function automatic logic [8:0] hdr_byte(
        input logic [3:0] idx,
        input logic [8:0] x0,
        input logic [8:0] x1,
        input logic [8:0] y0,
        input logic [8:0] y1
    );
        logic [8:0] w;
        case (idx)
            4'd0:    w = {1'b1, CMD_CASET};
            4'd1:    w = {1'b0, 7'd0, x0[8]};
            4'd2:    w = {1'b0, x0[7:0]};
            4'd3:    w = {1'b0, 7'd0, x1[8]};
            4'd4:    w = {1'b0, x1[7:0]};
            4'd5:    w = {1'b1, CMD_PASET};
            4'd6:    w = {1'b0, 7'd0, y0[8]};
            4'd7:    w = {1'b0, y0[7:0]};
            4'd8:    w = {1'b0, 7'd0, y1[8]};
            4'd9:    w = {1'b0, y1[7:0]};
            4'd10:   w = {1'b1, CMD_RAMWR};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lcd_fill_ctrl_handshake.sv
// One-byte LOAD/BUSY handshake towards the LCD byte interface.
// LOAD is held with stable data until BUSY is seen high, so a byte
// interface that samples LOAD only on a slow tick still catches it;
// the transfer completes when BUSY falls again.
module lcd_byte_handshake
    import lcd_fill_ctrl_pkg::*;
(
    input  logic       CLK_100MHz,
    input  logic       RESET,
    input  logic       go,
    input  logic [7:0] byte_in,
    input  logic       is_cmd_in,
    input  logic       lcd_busy,
    output logic       lcd_load,
    output logic [7:0] lcd_data,
    output logic       lcd_is_cmd,
    output logic       ack,
    output logic       done
);

    logic [1:0] phase_q;

    // Strobes are combinational so the sequencer moves on the same edge
    // the handshake changes phase.
    assign ack  = (phase_q == HS_LOAD) && lcd_busy;
    assign done = (phase_q == HS_WAIT) && !lcd_busy;

    // Launch a byte on go, hold LOAD until BUSY, then wait for BUSY to drop
    always_ff @(posedge CLK_100MHz or posedge RESET) begin
        if (RESET) begin
            phase_q    <= HS_IDLE;
            lcd_load   <= 1'b0;
            lcd_data   <= '0;
            lcd_is_cmd <= 1'b0;
        end else begin
            case (phase_q)
                HS_IDLE: begin
                    if (go) begin
                        lcd_data   <= byte_in;
                        lcd_is_cmd <= is_cmd_in;
                        lcd_load   <= 1'b1;
                        phase_q    <= HS_LOAD;
                    end
                end
                HS_LOAD: begin
                    if (lcd_busy) begin
                        lcd_load <= 1'b0;
                        phase_q  <= HS_WAIT;
                    end
                end
                HS_WAIT: begin
                    if (!lcd_busy) begin
                        phase_q <= HS_IDLE;
                    end
                end
                default: begin
                    lcd_load <= 1'b0;
                    phase_q  <= HS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_fill_ctrl.sv
// Rectangle fill controller: validates a window request, sends the
// CASET/PASET/RAMWR header, then streams N = width*height RGB565 pixels
// (hi byte then lo byte) through the byte handshake sub-module.
module lcd_fill_ctrl
    import lcd_fill_ctrl_pkg::*;
#(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic        CLK_100MHz,
    input  logic        RESET,
    input  logic        START,
    input  logic [8:0]  X0,
    input  logic [8:0]  X1,
    input  logic [8:0]  Y0,
    input  logic [8:0]  Y1,
    input  logic [15:0] COLOR,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        LCD_LOAD,
    output logic        LCD_IS_CMD,
    output logic [7:0]  LCD_DATA,
    input  logic        LCD_BUSY,
    input  logic        LCD_READY
);

    localparam logic [9:0] WIDTH_L  = 10'(WIDTH);
    localparam logic [9:0] HEIGHT_L = 10'(HEIGHT);

    logic [2:0]  state_q;
    logic [8:0]  x0_q, x1_q, y0_q, y1_q;
    logic [15:0] color_q;
    logic [3:0]  hdr_idx_q;
    logic        in_pix_q;
    logic        pix_lo_q;
    logic [16:0] pix_cnt_q;
    logic        calc_q;
    logic        err_q;

    logic        req_bad;
    logic [16:0] span_x, span_y;
    logic [8:0]  hdr_word;
    logic [7:0]  cur_byte;
    logic        cur_is_cmd;
    logic        last_byte;
    logic        hs_go, hs_ack, hs_done;

    assign req_bad = (X1 < X0) || (Y1 < Y0) ||
                     ({1'b0, X1} >= WIDTH_L) || ({1'b0, Y1} >= HEIGHT_L);

    assign span_x = 17'(x1_q - x0_q) + 17'd1;
    assign span_y = 17'(y1_q - y0_q) + 17'd1;

    assign last_byte = in_pix_q && pix_lo_q && (pix_cnt_q == 17'd1);
    assign hs_go     = (state_q == ST_ISSUE) && !LCD_BUSY;

    assign BUSY = (state_q != ST_IDLE);
    assign DONE = (state_q == ST_FINISH);
    assign ERR  = err_q;

    // Select the byte to send: header table first, then colour hi/lo
    always_comb begin
        hdr_word = hdr_byte(hdr_idx_q, x0_q, x1_q, y0_q, y1_q);
        if (in_pix_q) begin
            cur_is_cmd = 1'b0;
            cur_byte   = pix_lo_q ? color_q[7:0] : color_q[15:8];
        end else begin
            cur_is_cmd = hdr_word[8];
            cur_byte   = hdr_word[7:0];
        end
    end

    // Fill sequencer: request capture, pixel count, byte stepping
    always_ff @(posedge CLK_100MHz or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            color_q   <= '0;
            hdr_idx_q <= '0;
            in_pix_q  <= 1'b0;
            pix_lo_q  <= 1'b0;
            pix_cnt_q <= '0;
            calc_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            // Pixel count is formed once, from the latched bounds, the cycle
            // after an accepted START; it is only consumed after the header.
            if (calc_q) begin
                pix_cnt_q <= span_x * span_y;
                calc_q    <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        if (req_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            x0_q      <= X0;
                            x1_q      <= X1;
                            y0_q      <= Y0;
                            y1_q      <= Y1;
                            color_q   <= COLOR;
                            hdr_idx_q <= '0;
                            in_pix_q  <= 1'b0;
                            pix_lo_q  <= 1'b0;
                            calc_q    <= 1'b1;
                            state_q   <= ST_WAIT_READY;
                        end
                    end
                end
                ST_WAIT_READY: begin
                    if (LCD_READY && !LCD_BUSY) begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= LCD_BUSY ? ST_WAIT_READY : ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (hs_ack) begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (hs_done) begin
                        if (last_byte) begin
                            state_q <= ST_FINISH;
                        end else begin
                            if (!in_pix_q) begin
                                if (hdr_idx_q == HDR_LAST) begin
                                    in_pix_q <= 1'b1;
                                    pix_lo_q <= 1'b0;
                                end else begin
                                    hdr_idx_q <= hdr_idx_q + 4'd1;
                                end
                            end else if (!pix_lo_q) begin
                                pix_lo_q <= 1'b1;
                            end else begin
                                pix_lo_q  <= 1'b0;
                                pix_cnt_q <= pix_cnt_q - 17'd1;
                            end
                            state_q <= LCD_READY ? ST_ISSUE : ST_WAIT_READY;
                        end
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    lcd_byte_handshake u_handshake (
        .CLK_100MHz (CLK_100MHz),
        .RESET      (RESET),
        .go         (hs_go),
        .byte_in    (cur_byte),
        .is_cmd_in  (cur_is_cmd),
        .lcd_busy   (LCD_BUSY),
        .lcd_load   (LCD_LOAD),
        .lcd_data   (LCD_DATA),
        .lcd_is_cmd (LCD_IS_CMD),
        .ack        (hs_ack),
        .done       (hs_done)
    );

endmodule

// File: tb/tb_lcd_fill_ctrl.sv
// Bench for lcd_fill_ctrl: a behavioural LCD byte interface with
// configurable acknowledge delay captures every byte; expected byte
// streams are built from the window/colour rules directly.
module tb_lcd_fill_ctrl;

    logic        CLK_100MHz = 1'b0;
    logic        RESET;
    logic        START;
    logic [8:0]  X0, X1, Y0, Y1;
    logic [15:0] COLOR;
    logic        BUSY, DONE, ERR;
    logic        LCD_LOAD, LCD_IS_CMD;
    logic [7:0]  LCD_DATA;
    logic        LCD_BUSY = 1'b0;
    logic        LCD_READY;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 CLK_100MHz = ~CLK_100MHz;

    lcd_fill_ctrl #(.WIDTH(240), .HEIGHT(320)) dut (
        .CLK_100MHz (CLK_100MHz),
        .RESET      (RESET),
        .START      (START),
        .X0         (X0),
        .X1         (X1),
        .Y0         (Y0),
        .Y1         (Y1),
        .COLOR      (COLOR),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR),
        .LCD_LOAD   (LCD_LOAD),
        .LCD_IS_CMD (LCD_IS_CMD),
        .LCD_DATA   (LCD_DATA),
        .LCD_BUSY   (LCD_BUSY),
        .LCD_READY  (LCD_READY)
    );

    // LCD byte-interface model: after seeing LOAD for ack_delay cycles it
    // takes the byte and stays busy for busy_len cycles.
    int unsigned ack_delay  = 1;
    int unsigned busy_len   = 1;
    int unsigned m_state    = 0;
    int unsigned m_cnt      = 0;
    logic [8:0]  m_word     = '0;
    int unsigned hold_viol  = 0;
    int unsigned lbusy_viol = 0;
    logic [8:0]  rx_q[$];

    always @(negedge CLK_100MHz) begin
        if (RESET === 1'b1) begin
            m_state  = 0;
            m_cnt    = 0;
            LCD_BUSY = 1'b0;
        end else begin
            case (m_state)
                0: begin
                    if (LCD_LOAD === 1'b1) begin
                        m_word = {LCD_IS_CMD, LCD_DATA};
                        m_cnt  = 1;
                        if (m_cnt >= ack_delay) begin
                            rx_q.push_back(m_word);
                            LCD_BUSY = 1'b1;
                            m_cnt    = 0;
                            m_state  = 2;
                        end else begin
                            m_state = 1;
                        end
                    end
                end
                1: begin
                    if (LCD_LOAD !== 1'b1 || {LCD_IS_CMD, LCD_DATA} !== m_word)
                        hold_viol++;
                    m_cnt++;
                    if (m_cnt >= ack_delay) begin
                        rx_q.push_back(m_word);
                        LCD_BUSY = 1'b1;
                        m_cnt    = 0;
                        m_state  = 2;
                    end
                end
                2: begin
                    if (LCD_LOAD !== 1'b0) lbusy_viol++;
                    m_cnt++;
                    if (m_cnt >= busy_len) begin
                        LCD_BUSY = 1'b0;
                        m_state  = 0;
                    end
                end
                default: m_state = 0;
            endcase
        end
    end

    // Pulse/level counters sampled mid-cycle
    int unsigned done_cnt = 0;
    int unsigned err_cnt  = 0;
    int unsigned load_cnt = 0;

    always @(negedge CLK_100MHz) begin
        if (DONE === 1'b1)     done_cnt++;
        if (ERR === 1'b1)      err_cnt++;
        if (LCD_LOAD === 1'b1) load_cnt++;
    end

    logic [8:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Expected byte stream of a fill, straight from the window/colour rules
    function automatic void build_exp(input int x0, input int x1, input int y0,
                                      input int y1, input logic [15:0] c);
        logic [15:0] w;
        int unsigned n;
        exp_q.delete();
        exp_q.push_back({1'b1, 8'h2A});
        w = 16'(x0); exp_q.push_back({1'b0, w[15:8]}); exp_q.push_back({1'b0, w[7:0]});
        w = 16'(x1); exp_q.push_back({1'b0, w[15:8]}); exp_q.push_back({1'b0, w[7:0]});
        exp_q.push_back({1'b1, 8'h2B});
        w = 16'(y0); exp_q.push_back({1'b0, w[15:8]}); exp_q.push_back({1'b0, w[7:0]});
        w = 16'(y1); exp_q.push_back({1'b0, w[15:8]}); exp_q.push_back({1'b0, w[7:0]});
        exp_q.push_back({1'b1, 8'h2C});
        n = 32'((x1 - x0 + 1) * (y1 - y0 + 1));
        for (int unsigned p = 0; p < n; p++) begin
            exp_q.push_back({1'b0, c[15:8]});
            exp_q.push_back({1'b0, c[7:0]});
        end
    endfunction

    task automatic pulse_start(input int x0, input int x1, input int y0,
                               input int y1, input logic [15:0] c);
        @(posedge CLK_100MHz); #1;
        X0 = 9'(x0); X1 = 9'(x1); Y0 = 9'(y0); Y1 = 9'(y1); COLOR = c;
        START = 1'b1;
        @(posedge CLK_100MHz); #1;
        START = 1'b0;
    endtask

    task automatic finish_fill(input int unsigned rb, input int unsigned db,
                               input int unsigned tmo, input bit jit);
        int unsigned cyc;
        int unsigned got;
        cyc = 0;
        while (done_cnt == db && cyc < tmo) begin
            @(posedge CLK_100MHz); #1;
            cyc++;
            if (jit) LCD_READY = ($urandom_range(0, 3) != 0);
        end
        LCD_READY = 1'b1;
        chk("fill_timeout", 32'(done_cnt != db), 32'd1);
        repeat (4) @(posedge CLK_100MHz);
        #1;
        chk("done_once", done_cnt - db, 32'd1);
        chk("idle_after", 32'(BUSY), 32'd0);
        got = rx_q.size() - rb;
        chk("byte_count", got, exp_q.size());
        for (int unsigned i = 0; i < exp_q.size() && i < got; i++)
            chk($sformatf("byte%0d", i), 32'(rx_q[rb + i]), 32'(exp_q[i]));
        chk("hold_stable", hold_viol, 32'd0);
        chk("no_load_busy", lbusy_viol, 32'd0);
    endtask

    task automatic do_fill(input int x0, input int x1, input int y0, input int y1,
                           input logic [15:0] c, input int unsigned tmo, input bit jit);
        int unsigned rb, db;
        rb = rx_q.size();
        db = done_cnt;
        build_exp(x0, x1, y0, y1, c);
        pulse_start(x0, x1, y0, y1, c);
        chk("busy_after_start", 32'(BUSY), 32'd1);
        finish_fill(rb, db, tmo, jit);
    endtask

    task automatic do_bad(input int x0, input int x1, input int y0, input int y1);
        int unsigned lb, eb;
        lb = load_cnt;
        eb = err_cnt;
        pulse_start(x0, x1, y0, y1, 16'hFFFF);
        chk("err_pulse", 32'(ERR), 32'd1);
        chk("err_not_busy", 32'(BUSY), 32'd0);
        @(posedge CLK_100MHz); #1;
        chk("err_one_cycle", 32'(ERR), 32'd0);
        repeat (6) @(posedge CLK_100MHz);
        #1;
        chk("err_no_load", load_cnt - lb, 32'd0);
        chk("err_count", err_cnt - eb, 32'd1);
        chk("err_still_idle", 32'(BUSY), 32'd0);
    endtask

    initial begin
        int unsigned rb, db, lb, cyc;
        int x0, x1, y0, y1;

        RESET = 1'b1; START = 1'b0; LCD_READY = 1'b1;
        X0 = '0; X1 = '0; Y0 = '0; Y1 = '0; COLOR = '0;
        #1;
        chk("rst_busy",   32'(BUSY),       32'd0);
        chk("rst_done",   32'(DONE),       32'd0);
        chk("rst_err",    32'(ERR),        32'd0);
        chk("rst_load",   32'(LCD_LOAD),   32'd0);
        chk("rst_is_cmd", 32'(LCD_IS_CMD), 32'd0);
        chk("rst_data",   32'(LCD_DATA),   32'd0);
        repeat (3) @(posedge CLK_100MHz);
        #1 RESET = 1'b0;

        // 1x1 fill: 13 bytes
        do_fill(5, 5, 7, 7, 16'hF800, 2000, 1'b0);
        // full first row: 240 pixels
        do_fill(0, 239, 0, 0, 16'h1234, 20000, 1'b0);
        // bottom-right corner pixel is still inside the panel
        do_fill(239, 239, 319, 319, 16'($urandom), 2000, 1'b0);

        // rejected requests
        do_bad(10, 9, 0, 0);
        do_bad(0, 240, 0, 0);
        do_bad(0, 0, 6, 5);
        do_bad(0, 0, 0, 320);

        // slow-tick LCD: LOAD must be held for the full 100 cycles
        ack_delay = 100; busy_len = 3;
        do_fill(5, 5, 7, 7, 16'hF800, 5000, 1'b0);
        ack_delay = 1; busy_len = 1;

        // LCD not ready at START, plus a second START while busy
        rb = rx_q.size(); db = done_cnt; lb = load_cnt;
        LCD_READY = 1'b0;
        build_exp(1, 2, 3, 3, 16'h5A5A);
        pulse_start(1, 2, 3, 3, 16'h5A5A);
        chk("notready_busy", 32'(BUSY), 32'd1);
        repeat (20) @(posedge CLK_100MHz);
        #1;
        chk("notready_no_load", load_cnt - lb, 32'd0);
        pulse_start(7, 9, 4, 6, 16'h0001);
        repeat (5) @(posedge CLK_100MHz);
        #1;
        LCD_READY = 1'b1;
        finish_fill(rb, db, 2000, 1'b0);

        // randomized small windows with random LCD timing and READY dropouts
        for (int t = 0; t < 6; t++) begin
            ack_delay = $urandom_range(1, 4);
            busy_len  = $urandom_range(1, 4);
            x0 = int'($urandom_range(0, 236)); x1 = x0 + int'($urandom_range(0, 3));
            y0 = int'($urandom_range(0, 316)); y1 = y0 + int'($urandom_range(0, 3));
            do_fill(x0, x1, y0, y1, 16'($urandom), 5000, 1'b1);
        end
        ack_delay = 1; busy_len = 1;

        // reset in the middle of pixel 50 of a 10x10 fill
        rb = rx_q.size(); db = done_cnt;
        pulse_start(20, 29, 30, 39, 16'hABCD);
        cyc = 0;
        while (rx_q.size() < rb + 110 && cyc < 5000) begin
            @(posedge CLK_100MHz); #1;
            cyc++;
        end
        chk("reach_pixel50", 32'(rx_q.size() >= rb + 110), 32'd1);
        #1 RESET = 1'b1;
        #1;
        chk("midrst_load",   32'(LCD_LOAD),   32'd0);
        chk("midrst_data",   32'(LCD_DATA),   32'd0);
        chk("midrst_is_cmd", 32'(LCD_IS_CMD), 32'd0);
        chk("midrst_busy",   32'(BUSY),       32'd0);
        chk("midrst_done",   32'(DONE),       32'd0);
        repeat (2) @(posedge CLK_100MHz);
        #1 RESET = 1'b0;
        repeat (5) @(posedge CLK_100MHz);
        #1;
        chk("midrst_no_done", done_cnt - db, 32'd0);
        // 2x2 fill after reset: 11 header + 8 pixel bytes
        do_fill(3, 4, 8, 9, 16'h07E0, 2000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
